// File: rtl/hfrv_uart_pkg.sv
// Shared types and constants for the debug UART transmitter.
// DEBUG_UART_PARITY_EN selects an 8E1 frame (11 bits) instead of 8N1 (10 bits).
package hfrv_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int frame_bits();
`ifdef DEBUG_UART_PARITY_EN
        return UART_DATA_BITS + 3;
`else
        return UART_DATA_BITS + 2;
`endif
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers to tell full from empty.
// Head data is read combinationally so a pop can load it on the same edge.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/debug_uart_tx.sv
// Buffered transmit-only UART: FIFO + frame FSM + baud/bit counters + sticky overflow.
// Define DEBUG_UART_PARITY_EN to insert an even-parity bit (8E1); default is 8N1.
module debug_uart_tx
    import hfrv_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_DIV   = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            wr_valid,
    input  logic [7:0]                      wr_data,
    output logic                            wr_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    input  logic                            ovf_clr
);

    localparam int              CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_t   state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          baud_done;

    assign wr_ready  = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign baud_done = (baud_cnt == '0);

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_valid && wr_ready),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave it held (no latch).
        state_n    = state;
        baud_cnt_n = baud_done ? BAUD_LAST : baud_cnt - 1'b1;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                baud_cnt_n = baud_cnt;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_n    = fifo_head;
                    baud_cnt_n = BAUD_LAST;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef DEBUG_UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef DEBUG_UART_PARITY_EN
            PARITY: begin
                if (baud_done) state_n = STOP;
            end
`endif
            STOP: begin
                // Back-to-back frames: reload straight into START with no idle cycle.
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = fifo_head;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[bit_idx];
`ifdef DEBUG_UART_PARITY_EN
            PARITY:  tx = ^shreg;
`endif
            default: tx = 1'b1;
        endcase
    end

    // A new overflow on the same edge as a clear takes priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Self-checking bench for debug_uart_tx: directed scenarios plus random traffic,
// decoded by a line-level UART receiver model and compared against expected bytes.
module tb_debug_uart_tx;

    localparam int B     = 4;
    localparam int DEPTH = 16;
`ifdef DEBUG_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * B;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;

    always #5 clk = ~clk;

    debug_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .BAUD_DIV   (B)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       start_ok;
        logic       stop_ok;
        logic       par;
        int         t0;
    } frame_t;

    frame_t rx_q[$];

    // Line receiver: detects a falling edge, samples each bit at its centre.
    int         cyc = 0;
    bit         in_frame = 1'b0;
    int         f_t0;
    int         rel;
    int         bitn;
    logic [7:0] f_data;
    logic       f_start;
    logic       f_par = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset_n !== 1'b1) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                f_t0     = cyc;
            end
            if (in_frame) begin
                rel = cyc - f_t0;
                if (rel % B == B / 2) begin
                    bitn = rel / B;
                    if (bitn == 0) begin
                        f_start = tx;
                    end else if (bitn <= 8) begin
                        f_data[bitn-1] = tx;
                    end else if (bitn == FB - 1) begin
                        rx_q.push_back('{data: f_data, start_ok: (f_start === 1'b0),
                                         stop_ok: (tx === 1'b1), par: f_par, t0: f_t0});
                        in_frame = 1'b0;
                    end else begin
                        f_par = tx;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
        check({tag, "_idle"}, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
        check({tag, "_rx_count"}, rx_q.size(), n);
    endtask

    // Writes one byte from idle and compares the line cycle by cycle with the 8N1/8E1 frame.
    task automatic frame_wave(input logic [7:0] d, input string tag);
        logic [FB-1:0] bits;
        int            mism;
        int            first_bad;
        bits       = '1;
        bits[0]    = 1'b0;
        bits[8:1]  = d;
`ifdef DEBUG_UART_PARITY_EN
        bits[9]    = ^d;
`endif
        mism      = 0;
        first_bad = -1;
        rx_q.delete();
        write_byte(d);
        check({tag, "_count_after_write"}, fifo_count, 1);
        check({tag, "_tx_before_start"}, tx, 1'b1);
        check({tag, "_busy_after_write"}, busy, 1'b1);
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            if (tx !== bits[j/B]) begin
                mism++;
                if (first_bad < 0) first_bad = j;
            end
            if (j == FRAME / 2) check({tag, "_busy_mid"}, busy, 1'b1);
        end
        check({tag, "_wave_bad_cycles"}, mism, 0);
        @(negedge clk);
        check({tag, "_tx_after_frame"}, tx, 1'b1);
        check({tag, "_busy_after_frame"}, busy, 1'b0);
        check({tag, "_count_after_frame"}, fifo_count, 0);
        wait_rx(tag, 1, 20);
        check({tag, "_rx_data"}, rx_q[0].data, d);
        check({tag, "_rx_stop"}, rx_q[0].stop_ok, 1'b1);
    endtask

    logic [7:0] exp_q[$];
    int         peak;
    logic [7:0] b;
    string      got;

    initial begin
        // Reset values
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames, exact timing
        frame_wave(8'h55, "w55");
        wait_idle("w55", 100);
        frame_wave(8'h07, "w07");
`ifdef DEBUG_UART_PARITY_EN
        check("w07_parity", rx_q[0].par, 1'b1);
`endif
        wait_idle("w07", 100);
        frame_wave(8'h03, "w03");
`ifdef DEBUG_UART_PARITY_EN
        check("w03_parity", rx_q[0].par, 1'b0);
`endif
        wait_idle("w03", 100);

        // Burst of three on consecutive cycles
        rx_q.delete();
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h41 + 8'(i);
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 3 * FRAME + 50 && rx_q.size() < 3; i++) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("abc_count_peak", peak, 2);
        check("abc_rx_count", rx_q.size(), 3);
        got = "";
        for (int i = 0; i < 3; i++) got = {got, string'(rx_q[i].data)};
        check("abc_string", (got == "ABC") ? 1 : 0, 1);
        check("abc_gap_1", rx_q[1].t0 - rx_q[0].t0, FRAME);
        check("abc_gap_2", rx_q[2].t0 - rx_q[1].t0, FRAME);
        wait_idle("abc", 200);

        // Overflow: fill behind an in-flight frame, then one more write
        rx_q.delete();
        exp_q.delete();
        b = 8'($urandom);
        exp_q.push_back(b);
        write_byte(b);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            b        = 8'($urandom);
            wr_valid = 1'b1;
            wr_data  = b;
            if (i < 16) exp_q.push_back(b);
            @(negedge clk);
            if (i == 15) begin
                check("ovf_full_wr_ready", wr_ready, 1'b0);
                check("ovf_full_count", fifo_count, 16);
                check("ovf_not_yet", overflow, 1'b0);
            end
        end
        wr_valid = 1'b0;
        check("ovf_set", overflow, 1'b1);
        check("ovf_count_unchanged", fifo_count, 16);
        repeat (4) @(negedge clk);
        check("ovf_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        check("ovf_still_full", wr_ready, 1'b0);
        ovf_clr  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        @(negedge clk);
        ovf_clr  = 1'b0;
        wr_valid = 1'b0;
        check("ovf_set_beats_clr", overflow, 1'b1);
        check("ovf_count_after_drop", fifo_count, 16);
        wait_rx("ovf", 17, 17 * FRAME + 100);
        for (int i = 0; i < 17; i++) begin
            check($sformatf("ovf_rx_%0d", i), rx_q[i].data, exp_q[i]);
        end
        wait_idle("ovf", 200);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;

        // Reset during data bit 3, with a second byte queued
        rx_q.delete();
        write_byte(8'hCB);
        write_byte(8'h99);
        repeat (17) @(negedge clk);
        check("rst_mid_count_before", fifo_count, 1);
        check("rst_mid_bit3", tx, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_count", fifo_count, 0);
        check("rst_mid_busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
        write_byte(8'hA5);
        wait_rx("rst_a5", 1, FRAME + 20);
        repeat (2 * FRAME) @(negedge clk);
        check("rst_a5_only_one", rx_q.size(), 1);
        check("rst_a5_data", rx_q[0].data, 8'hA5);
        check("rst_a5_start", rx_q[0].start_ok, 1'b1);
        check("rst_a5_stop", rx_q[0].stop_ok, 1'b1);
        wait_idle("rst_a5", 100);

        // Random traffic with random gaps; never more than 12 pending, so never full
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            check($sformatf("rnd_ready_%0d", i), wr_ready, 1'b1);
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
        end
        wait_rx("rnd", 12, 12 * FRAME + 200);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("rnd_rx_%0d", i), rx_q[i].data, exp_q[i]);
            check($sformatf("rnd_stop_%0d", i), rx_q[i].stop_ok, 1'b1);
`ifdef DEBUG_UART_PARITY_EN
            check($sformatf("rnd_par_%0d", i), rx_q[i].par, ^exp_q[i]);
`endif
        end
        check("rnd_no_overflow", overflow, 1'b0);
        wait_idle("rnd", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
